cpu_trace_buffer: RTL

- Downstream consumer of the single-cycle CPU's per-cycle debug outputs: the PC (`counter`), the fetched `instruction` and `ALUout`.
- Records one trace entry per clock into a circular buffer, with a masked instruction-match trigger and a configurable post-trigger window.
- After capture, plays records back oldest-first over a valid/ready port to a host or bench.
- Replaces ad-hoc `$display` tracing with a synthesizable logic-analyzer stage.

---
 rtl/trace_pkg.sv | 36 +++
 rtl/trace_ram.sv | 40 ++++
 rtl/cpu_trace_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Purpose  : Shared definitions for the CPU trace buffer: capture state
//             encoding, trace record width and record field positions, and
//             a helper that packs one CPU cycle into a record.
//  Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // One trace record: {counter, instruction, ALUout}
    localparam int REC_W    = 160;
    localparam int CNT_MSB  = 159;
    localparam int CNT_LSB  = 96;
    localparam int INST_MSB = 95;
    localparam int INST_LSB = 64;
    localparam int ALU_MSB  = 63;
    localparam int ALU_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRETRIG  = 2'd1,
        POSTTRIG = 2'd2,
        DONE     = 2'd3
    } trace_state_t;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [63:0] pc,
        input logic [31:0] inst,
        input logic [63:0] alu
    );
        return {pc, inst, alu};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
//  Module   : trace_ram
//  Purpose  : Record storage for the trace buffer. DEPTH x WIDTH array with
//             a synchronous write port and an asynchronous read port, so the
//             readout record follows the read pointer in the same cycle.
//  Ports    : clock  - write clock
//             we     - write enable
//             waddr  - write address
//             wdata  - write record
//             raddr  - read address
//             rdata  - read record (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module trace_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 160
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    // Contents are intentionally not reset; fill tracks which entries are valid.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_trace_buffer
//  Purpose  : Logic-analyzer stage for the single-cycle CPU. Captures one
//             {PC, instruction, ALU result} record per clock into a circular
//             buffer, stops POST_TRIG records after a masked instruction
//             match, then plays the held records back oldest-first over a
//             valid/ready port.
//  Ports    : clock, reset            - clock, async active-high reset
//             arm                     - clear buffer and start capture
//             trig_en/inst/mask       - trigger compare controls
//             counter/instruction/ALUout - CPU debug inputs
//             rd_valid/rd_ready/rd_*  - readout handshake and record
//             state, fill, triggered  - capture status
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int POST_TRIG = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [31:0]       trig_inst,
    input  logic [31:0]       trig_mask,
    input  logic [63:0]       counter,
    input  logic [31:0]       instruction,
    input  logic [63:0]       ALUout,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [63:0]       rd_counter,
    output logic [31:0]       rd_instruction,
    output logic [63:0]       rd_aluout,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   fill,
    output logic              triggered
);

    localparam logic [ADDR_W-1:0] c_one_ptr  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_one_fill = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_post     = ADDR_W'(POST_TRIG);

    trace_state_t      r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [ADDR_W:0]   r_fill;
    logic              r_triggered;

    logic              w_hit;
    logic              w_capture;
    logic              w_rd_valid;
    logic              w_rd_xfer;
    logic [ADDR_W-1:0] w_wr_next;
    logic [ADDR_W:0]   w_fill_next;
    logic [ADDR_W-1:0] w_post_next;
    logic [ADDR_W-1:0] w_oldest;
    logic [REC_W-1:0]  w_wr_rec;
    logic [REC_W-1:0]  w_rd_rec;

    assign w_hit = trig_en && ((instruction & trig_mask) == (trig_inst & trig_mask));

    // An arm pulse restarts capture, so it suppresses the write in its own cycle.
    assign w_capture   = ((r_state == PRETRIG) || (r_state == POSTTRIG)) && !arm;
    assign w_wr_next   = r_wr_ptr + c_one_ptr;
    assign w_fill_next = (r_fill == c_depth) ? r_fill : (r_fill + c_one_fill);
    assign w_post_next = r_post_cnt + c_one_ptr;
    // Oldest record after this cycle's write. When full the low bits of the
    // fill count are zero, which lands on the slot about to be overwritten.
    assign w_oldest    = w_wr_next - w_fill_next[ADDR_W-1:0];

    assign w_rd_valid  = (r_state == DONE) && (r_fill != '0);
    assign w_rd_xfer   = w_rd_valid && rd_ready;
    assign w_wr_rec    = pack_record(counter, instruction, ALUout);

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (REC_W)
    ) u_ram (
        .clock (clock),
        .we    (w_capture),
        .waddr (r_wr_ptr),
        .wdata (w_wr_rec),
        .raddr (r_rd_ptr),
        .rdata (w_rd_rec)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_post_cnt  <= '0;
            r_fill      <= '0;
            r_triggered <= 1'b0;
        end else if (arm) begin
            // arm outranks everything, including a coincident trigger hit
            r_state     <= PRETRIG;
            r_wr_ptr    <= '0;
            r_post_cnt  <= '0;
            r_fill      <= '0;
            r_triggered <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                PRETRIG: begin
                    r_wr_ptr <= w_wr_next;
                    r_fill   <= w_fill_next;
                    if (w_hit) begin
                        r_triggered <= 1'b1;
                        r_post_cnt  <= '0;
                        if (POST_TRIG == 0) begin
                            r_state  <= DONE;
                            r_rd_ptr <= w_oldest;
                        end else begin
                            r_state  <= POSTTRIG;
                        end
                    end
                end
                POSTTRIG: begin
                    r_wr_ptr   <= w_wr_next;
                    r_fill     <= w_fill_next;
                    r_post_cnt <= w_post_next;
                    if (w_post_next == c_post) begin
                        r_state  <= DONE;
                        r_rd_ptr <= w_oldest;
                    end
                end
                DONE: begin
                    if (w_rd_xfer) begin
                        r_rd_ptr <= r_rd_ptr + c_one_ptr;
                        r_fill   <= r_fill - c_one_fill;
                        if (r_fill == c_one_fill) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_valid       = w_rd_valid;
    assign rd_counter     = w_rd_rec[CNT_MSB:CNT_LSB];
    assign rd_instruction = w_rd_rec[INST_MSB:INST_LSB];
    assign rd_aluout      = w_rd_rec[ALU_MSB:ALU_LSB];
    assign state          = r_state;
    assign fill           = r_fill;
    assign triggered      = r_triggered;

endmodule
`default_nettype wire
